// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SERIAL_SUB_WIDTH = 8;

endpackage

// File: rtl/fullsub.sv
// One-bit full subtractor: d = a - b - bin, bo = borrow out.
// Purely combinational cell.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & bin) | (~a & b) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Operands in and result out over valid/ready handshakes.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t state, nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [CW-1:0]    bit_cnt;
  logic             brw;
  logic             d;
  logic             bo;

  fullsub u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (brw),
    .d   (d),
    .bo  (bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid) nxt = RUN;
      RUN:     if (bit_cnt == LAST) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      bit_cnt <= '0;
      brw     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh    <= a;
      b_sh    <= b;
      brw     <= bin;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      // Result bits enter at the MSB so the LSB lands at bit 0 last.
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      diff_sh <= {d, diff_sh[WIDTH-1:1]};
      brw     <= bo;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign diff       = diff_sh;
  assign borrow_out = brw;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle unsigned subtractor built around the team's one-bit full-subtractor cell. It accepts a WIDTH-bit minuend/subtrahend pair plus a borrow-in over a valid/ready handshake. It then processes one bit per clock, LSB first, keeping the running borrow in a flop, and presents the WIDTH-bit difference and final borrow on a second valid/ready handshake. It sits directly upstream of any consumer of subtraction results and is the sequential wrapper that feeds operand bits to the full-subtractor cell and consumes its diff/borrow outputs.

## Interface
- WIDTH, 8: operand and result width in bits; legal range ≥ 2.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  minuend, unsigned.
- b  in  WIDTH  subtrahend, unsigned.
- bin  in  1  borrow-in for the LSB, used for multi-word chaining.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- diff  out  WIDTH  result: (a − b − bin) mod 2^WIDTH.
- borrow_out  out  1  final borrow; 1 iff a < b + bin (unsigned).

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE: in_ready=1.
  - On in_valid && in_ready, the block captures a→a_sh, b→b_sh and bin→brw, clears bit_cnt to 0, and moves to RUN.
- RUN, every cycle:
  - The cell computes d = a_sh[0]^b_sh[0]^brw and bo = (~a_sh[0]&brw)|(~a_sh[0]&b_sh[0])|(b_sh[0]&brw).
  - a_sh and b_sh shift right by 1.
  - d shifts into the MSB of diff_sh, which shifts right.
  - brw ← bo and bit_cnt increments.
  - At bit_cnt==WIDTH−1 the state moves to DONE.
- DONE: out_valid=1. diff = diff_sh and borrow_out = brw, both held stable.
  - On out_ready the state moves to IDLE.
  - out_ready low stalls the block indefinitely with outputs frozen.
- diff and borrow_out retain the last result in IDLE. They change only during RUN.
- in_valid in RUN or DONE is ignored, because in_ready=0. Operands are sampled only at the accept edge, so later changes to a/b/bin have no effect.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits wide.
  - No sign handling; the result wraps modulo 2^WIDTH, and borrow_out is the underflow indicator.

## Timing
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, diff=0, borrow_out=0, brw=0, bit_cnt=0.
- Latency: if operands are accepted at edge E0, the RUN edges are E1..E_WIDTH and out_valid is high from edge E_WIDTH onward. That is, out_valid rises exactly WIDTH cycles after acceptance.
- Throughput is one result per WIDTH+2 cycles with out_ready tied high. DONE→IDLE takes one cycle, and no operands are accepted in the DONE cycle.
- out_valid falls on the edge after the cycle in which out_valid && out_ready.
- Reset asserted mid-RUN or in DONE aborts immediately, without waiting for a clock edge. All registers go to their reset values and no out_valid pulse is produced.
- The in_ready/out_valid handshake signals are pure state decodes, with no combinational path from in_valid or out_ready.

## Structure
- The shared package serial_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constant SERIAL_SUB_WIDTH = 8.
- One sub-module is natural: the existing combinational one-bit full-subtractor cell fullsub, instantiated once.
  - Its inputs are a_sh[0], b_sh[0] and brw.
  - Its outputs are d and bo.
- The top level contains only the FSM, the shift registers, bit_cnt and brw.

## Test plan
- WIDTH=8, a=5, b=3, bin=0 → after 8 cycles out_valid=1, diff=2, borrow_out=0.
- a=3, b=5, bin=0 → diff=254 (0xFE), borrow_out=1. Also a=0, b=0, bin=1 → diff=255, borrow_out=1.
- a=255, b=255, bin=0 → diff=0, borrow_out=0. Then exhaustive 4-bit sweep (WIDTH=4, all a, b, bin) against (a−b−bin) mod 16 and the borrow.
- Hold out_ready=0 for 10 cycles in DONE → out_valid, diff and borrow_out stable, and in_ready=0. Raise out_ready → IDLE the next cycle and in_ready=1.
- Toggle a/b and pulse in_valid during RUN → result unchanged from the originally accepted operands, and no second acceptance.
- Deassert rst_n at RUN cycle 3 → out_valid=0, diff=0, borrow_out=0, in_ready=1 immediately. A new operation after release completes with correct latency.
